// File: rtl/add_round_key_stage.sv
// AES-128 AddRoundKey stage: XORs each accepted state with the round key
// selected by an internal round counter and holds it in a one-entry valid/ready output register.
module add_round_key_stage #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         keyWe,
  input  logic [3:0]   keyIdx,
  input  logic [0:127] keyIn,
  input  logic         restart,
  input  logic         inValid,
  output logic         inReady,
  input  logic [0:127] stateIn,
  output logic         outValid,
  input  logic         outReady,
  output logic [0:127] stateOut,
  output logic [3:0]   round,
  output logic         lastRound
);

  localparam logic [3:0] LAST = 4'(NR);

  function automatic logic [0:127] add_key(input logic [0:127] s, input logic [0:127] k);
    return s ^ k;
  endfunction

  logic [0:127] r_keys [0:NR];
  logic [3:0]   r_rnd;

  logic         r_vld_p1;
  logic [0:127] r_state_p1;
  logic [3:0]   r_round_p1;
  logic         r_last_p1;

  logic         w_accept;
  logic [3:0]   w_rndSel;
  logic [3:0]   w_rndNext;
  logic [0:127] w_key;

  assign inReady   = !r_vld_p1 || outReady;
  assign w_accept  = inValid && inReady;
  // restart applies before the lookup, so a restarting accept uses key[0]
  assign w_rndSel  = restart ? 4'd0 : r_rnd;
  assign w_rndNext = (w_rndSel == LAST) ? 4'd0 : w_rndSel + 4'd1;
  assign w_key     = r_keys[w_rndSel];

  // Stage p0 -> p1: key lookup and XOR into the output register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p1   <= 1'b0;
      r_state_p1 <= '0;
      r_round_p1 <= '0;
      r_last_p1  <= 1'b0;
      r_rnd      <= '0;
      for (int i = 0; i <= NR; i++) r_keys[i] <= '0;
    end else begin
      // Writes to indices above NR match no entry and are dropped
      for (int i = 0; i <= NR; i++) begin
        if (keyWe && keyIdx == 4'(i)) r_keys[i] <= keyIn;
      end
      if (w_accept) begin
        r_state_p1 <= add_key(stateIn, w_key);
        r_round_p1 <= w_rndSel;
        r_last_p1  <= (w_rndSel == LAST);
        r_rnd      <= w_rndNext;
      end else if (restart) begin
        r_rnd <= '0;
      end
      if (w_accept)      r_vld_p1 <= 1'b1;
      else if (outReady) r_vld_p1 <= 1'b0;
    end
  end

  assign outValid  = r_vld_p1;
  assign stateOut  = r_state_p1;
  assign round     = r_round_p1;
  assign lastRound = r_last_p1;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed self-checking bench for add_round_key_stage using FIPS-197 round keys.
module tb_add_round_key_stage;

  logic         clk = 1'b0;
  logic         reset, keyWe, restart, inValid, outReady;
  logic [3:0]   keyIdx;
  logic [0:127] keyIn, stateIn;
  logic         inReady, outValid, lastRound;
  logic [0:127] stateOut;
  logic [3:0]   round;

  int n_checks = 0;
  int n_errors = 0;

  logic [127:0] rk [0:10];
  logic [127:0] s, held_state, newk;
  logic [3:0]   held_round;

  add_round_key_stage #(.NR(10)) dut (
    .clk(clk), .reset(reset), .keyWe(keyWe), .keyIdx(keyIdx), .keyIn(keyIn),
    .restart(restart), .inValid(inValid), .inReady(inReady), .stateIn(stateIn),
    .outValid(outValid), .outReady(outReady), .stateOut(stateOut),
    .round(round), .lastRound(lastRound)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [127:0] st);
    inValid = 1'b1;
    stateIn = st;
    step();
    inValid = 1'b0;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    step();
    restart = 1'b0;
  endtask

  initial begin
    rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    reset = 1'b1; keyWe = 1'b0; keyIdx = '0; keyIn = '0; restart = 1'b0;
    inValid = 1'b0; stateIn = '0; outReady = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_outValid", 128'(outValid), 128'd0);
    chk("rst_stateOut", stateOut, 128'd0);
    chk("rst_round", 128'(round), 128'd0);
    chk("rst_lastRound", 128'(lastRound), 128'd0);
    chk("rst_inReady", 128'(inReady), 128'd1);

    // Round 0 with the FIPS-197 example
    keyWe = 1'b1; keyIdx = 4'd0; keyIn = rk[0];
    step();
    keyWe = 1'b0;
    accept(128'h3243f6a8885a308d313198a2e0370734);
    chk("r0_outValid", 128'(outValid), 128'd1);
    chk("r0_stateOut", stateOut, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    chk("r0_round", 128'(round), 128'd0);
    chk("r0_lastRound", 128'(lastRound), 128'd0);
    step();
    chk("drain_outValid", 128'(outValid), 128'd0);
    chk("drain_stateOut_hold", stateOut, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    do_restart();

    // Full block, back-to-back, then wrap
    for (int k = 0; k < 11; k++) begin
      keyWe = 1'b1; keyIdx = 4'(k); keyIn = rk[k];
      step();
    end
    keyWe = 1'b0;
    for (int r = 0; r < 12; r++) begin
      s = {16{8'(r * 17 + 3)}};
      accept(s);
      chk("blk_stateOut", stateOut, s ^ rk[r % 11]);
      chk("blk_round", 128'(round), 128'(r % 11));
      chk("blk_lastRound", 128'(lastRound), 128'(r == 10));
      chk("blk_outValid", 128'(outValid), 128'd1);
    end

    // Backpressure: output held, no advance of the round counter
    held_state = stateOut; held_round = round;
    outReady = 1'b0; inValid = 1'b1; stateIn = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    #1;
    chk("bp_inReady", 128'(inReady), 128'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_outValid", 128'(outValid), 128'd1);
      chk("bp_stateOut", stateOut, held_state);
      chk("bp_round", 128'(round), 128'(held_round));
      chk("bp_inReady_hold", 128'(inReady), 128'd0);
    end
    outReady = 1'b1;
    #1;
    chk("bp_release_inReady", 128'(inReady), 128'd1);
    step();
    inValid = 1'b0;
    chk("bp_next_stateOut", stateOut, 128'hdeadbeef_01234567_89abcdef_cafef00d ^ rk[1]);
    chk("bp_next_round", 128'(round), 128'd1);

    // restart coincident with an accept
    do_restart();
    for (int r = 0; r < 4; r++) begin
      accept(128'h0123456789abcdef0123456789abcdef);
      chk("rs_pre_round", 128'(round), 128'(r));
    end
    restart = 1'b1;
    accept('0);
    restart = 1'b0;
    chk("rs_stateOut", stateOut, rk[0]);
    chk("rs_round", 128'(round), 128'd0);
    accept('0);
    chk("rs_next_stateOut", stateOut, rk[1]);
    chk("rs_next_round", 128'(round), 128'd1);

    // Out-of-range key writes leave every entry intact
    keyWe = 1'b1; keyIdx = 4'd11; keyIn = '1;
    step();
    keyIdx = 4'd15;
    step();
    keyWe = 1'b0;
    do_restart();
    for (int r = 0; r < 11; r++) begin
      accept('0);
      chk("oor_key", stateOut, rk[r]);
    end

    // Read-before-write on the key being used (rnd has wrapped to 0)
    newk = 128'h00112233445566778899aabbccddeeff;
    keyWe = 1'b1; keyIdx = 4'd0; keyIn = newk;
    accept('0);
    keyWe = 1'b0;
    chk("rbw_old_key", stateOut, rk[0]);
    chk("rbw_round", 128'(round), 128'd0);
    do_restart();
    accept('0);
    chk("rbw_new_key", stateOut, newk);

    // Reset with a pending output and rnd = 5
    do_restart();
    for (int r = 0; r < 5; r++) accept(128'hffff0000ffff0000ffff0000ffff0000);
    chk("pre_rst_outValid", 128'(outValid), 128'd1);
    chk("pre_rst_round", 128'(round), 128'd4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_outValid", 128'(outValid), 128'd0);
    chk("mid_rst_round", 128'(round), 128'd0);
    chk("mid_rst_stateOut", stateOut, 128'd0);
    s = 128'h3243f6a8885a308d313198a2e0370734;
    accept(s);
    chk("post_rst_stateOut", stateOut, s);
    chk("post_rst_round", 128'(round), 128'd0);
    chk("post_rst_outValid", 128'(outValid), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
